// File: rtl/alu_sout_deser.sv
// alu_sout_deser: deserializer for the serial ALU output line.
// Collects 11-bit frames (start, type, 8 data bits MSB first, stop).
// Groups them into packets: DATA_FRAMES data frames followed by a result
// CTL frame, or a single error CTL frame. Results and errors are reported
// with one-cycle strobes.
// Optional feature macro: ALU_SOUT_CRC3_CHECK_EN. When it is defined, the
// CRC3 of the result is checked. When it is undefined, crc_ok reads 1 on
// every result.
module alu_sout_deser #(
    parameter int DATA_FRAMES  = 4,   // only 4 is supported (C is 32 bits)
    parameter int IDLE_TIMEOUT = 64   // 0 disables the inter-frame timeout
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sout,
    output logic        result_valid,
    output logic [31:0] c,
    output logic [3:0]  flags,
    output logic [2:0]  crc3,
    output logic        crc_ok,
    output logic        err_valid,
    output logic [2:0]  err_flags,
    output logic        parity_ok,
    output logic        proto_err
);

    localparam int CW = $clog2(DATA_FRAMES + 1);
    localparam int TW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, TYPE, DATA, STOP} state_t;

    state_t        state;
    logic          is_ctl;
    logic [7:0]    sh;
    logic [2:0]    bit_cnt;
    logic [CW-1:0] frame_cnt;
    logic [TW-1:0] idle_cnt;
    logic [31:0]   c_shift;

`ifdef ALU_SOUT_CRC3_CHECK_EN
    // CRC3, polynomial x^3+x+1, init 0, message fed MSB first
    function automatic logic [2:0] crc3_calc(input logic [36:0] msg);
        logic [2:0] r;
        logic       fb;
        r = 3'b000;
        for (int i = 36; i >= 0; i--) begin
            fb = r[2] ^ msg[i];
            r  = {r[1], r[0] ^ fb, fb};
        end
        return r;
    endfunction
`endif

    // Frame FSM plus packet decode; all outputs are registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            is_ctl       <= 1'b0;
            sh           <= '0;
            bit_cnt      <= '0;
            frame_cnt    <= '0;
            idle_cnt     <= '0;
            c_shift      <= '0;
            result_valid <= 1'b0;
            err_valid    <= 1'b0;
            proto_err    <= 1'b0;
            c            <= '0;
            flags        <= '0;
            crc3         <= '0;
            crc_ok       <= 1'b0;
            err_flags    <= '0;
            parity_ok    <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            err_valid    <= 1'b0;
            proto_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (!sout) begin
                        state    <= TYPE;
                        idle_cnt <= '0;
                    end else if (IDLE_TIMEOUT > 0 && frame_cnt != '0) begin
                        // idle_cnt counts idle cycles already seen; firing at
                        // equality means this is cycle IDLE_TIMEOUT+1
                        if (idle_cnt == TW'(IDLE_TIMEOUT)) begin
                            proto_err <= 1'b1;
                            frame_cnt <= '0;
                            idle_cnt  <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end else begin
                        idle_cnt <= '0;
                    end
                end
                TYPE: begin
                    is_ctl  <= sout;
                    bit_cnt <= '0;
                    state   <= DATA;
                end
                DATA: begin
                    sh      <= {sh[6:0], sout};
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7) state <= STOP;
                end
                STOP: begin
                    state    <= IDLE;
                    idle_cnt <= '0;
                    if (!sout) begin
                        proto_err <= 1'b1;
                        frame_cnt <= '0;
                    end else if (!is_ctl) begin
                        if (frame_cnt != CW'(DATA_FRAMES)) begin
                            c_shift   <= {c_shift[23:0], sh};
                            frame_cnt <= frame_cnt + 1'b1;
                        end else begin
                            proto_err <= 1'b1;
                            frame_cnt <= '0;
                        end
                    end else if (!sh[7]) begin
                        frame_cnt <= '0;
                        if (frame_cnt == CW'(DATA_FRAMES)) begin
                            result_valid <= 1'b1;
                            c            <= c_shift;
                            flags        <= sh[6:3];
                            crc3         <= sh[2:0];
`ifdef ALU_SOUT_CRC3_CHECK_EN
                            crc_ok <= (crc3_calc({c_shift, 1'b0, sh[6:3]}) == sh[2:0]);
`else
                            crc_ok <= 1'b1;
`endif
                        end else begin
                            proto_err <= 1'b1;
                        end
                    end else begin
                        // error response: any partial packet is dropped
                        err_valid <= 1'b1;
                        err_flags <= sh[6:4];
                        parity_ok <= (^sh == 1'b0) && (sh[3:1] == sh[6:4]);
                        frame_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sout_deser.sv
// Bench for alu_sout_deser. The stimulus tasks drive whole frames and
// packets. A packet-level model predicts the strobe and the held outputs
// for every cycle. A compare process checks the DUT on each falling edge.
module tb_alu_sout_deser;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sout = 1'b1;
    logic        result_valid, crc_ok, err_valid, parity_ok, proto_err;
    logic [31:0] c;
    logic [3:0]  flags;
    logic [2:0]  crc3, err_flags;

    alu_sout_deser #(.DATA_FRAMES(4), .IDLE_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .sout(sout),
        .result_valid(result_valid), .c(c), .flags(flags), .crc3(crc3),
        .crc_ok(crc_ok), .err_valid(err_valid), .err_flags(err_flags),
        .parity_ok(parity_ok), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // model state
    int          exp_kind [int];   // cycle -> 1 result, 2 error, 3 proto
    int          m_cnt, m_idle;
    logic [31:0] m_sh, m_c;
    logic [3:0]  m_flags;
    logic [2:0]  m_crc3, m_err;
    logic        m_crc_ok, m_par;
    int          res_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // CRC3 as the remainder of M(x)*x^3 divided by x^3+x+1
    function automatic logic [2:0] crc_model(input logic [31:0] cv, input logic [3:0] f);
        logic [39:0] m;
        m = {cv, 1'b0, f, 3'b000};
        for (int i = 39; i >= 3; i--)
            if (m[i]) m[i -: 4] = m[i -: 4] ^ 4'b1011;
        return m[2:0];
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_idle = 0; m_sh = '0; m_c = '0; m_flags = '0;
        m_crc3 = '0; m_err = '0; m_crc_ok = 1'b0; m_par = 1'b0;
        exp_kind.delete();
    endtask

    // per-cycle check of strobes and held outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            int k;
            k = exp_kind.exists(cyc) ? exp_kind[cyc] : 0;
            if (exp_kind.exists(cyc)) exp_kind.delete(cyc);
            if (result_valid === 1'b1) res_cyc.push_back(cyc);
            chk("result_valid", result_valid, k == 1);
            chk("err_valid", err_valid, k == 2);
            chk("proto_err", proto_err, k == 3);
            chk("c", c, m_c);
            chk("flags", flags, m_flags);
            chk("crc3", crc3, m_crc3);
            chk("crc_ok", crc_ok, m_crc_ok);
            chk("err_flags", err_flags, m_err);
            chk("parity_ok", parity_ok, m_par);
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            sout = 1'b1;
            @(posedge clk); #1;
            if (m_cnt > 0) begin
                m_idle++;
                if (m_idle > TO) begin
                    exp_kind[cyc] = 3;
                    m_cnt = 0;
                    m_idle = 0;
                end
            end
        end
    endtask

    task automatic send_frame(input bit typ, input logic [7:0] b, input bit stop = 1'b1);
        logic [10:0] fr;
        fr = {1'b0, typ, b, stop};
        m_idle = 0;
        for (int i = 10; i >= 0; i--) begin
            sout = fr[i];
            @(posedge clk); #1;
        end
        if (!stop) begin
            exp_kind[cyc] = 3; m_cnt = 0;
        end else if (!typ) begin
            if (m_cnt < 4) begin
                m_sh = {m_sh[23:0], b}; m_cnt++;
            end else begin
                exp_kind[cyc] = 3; m_cnt = 0;
            end
        end else if (!b[7]) begin
            if (m_cnt == 4) begin
                exp_kind[cyc] = 1;
                m_c = m_sh; m_flags = b[6:3]; m_crc3 = b[2:0];
`ifdef ALU_SOUT_CRC3_CHECK_EN
                m_crc_ok = (crc_model(m_sh, b[6:3]) == b[2:0]);
`else
                m_crc_ok = 1'b1;
`endif
            end else begin
                exp_kind[cyc] = 3;
            end
            m_cnt = 0;
        end else begin
            exp_kind[cyc] = 2;
            m_err = b[6:4];
            m_par = (^b == 1'b0) && (b[3:1] == b[6:4]);
            m_cnt = 0;
        end
    endtask

    task automatic send_packet(input logic [31:0] cv, input logic [3:0] f, input bit inv = 1'b0);
        logic [2:0] cr;
        for (int i = 0; i < 4; i++) send_frame(1'b0, cv[31 - 8*i -: 8]);
        cr = crc_model(cv, f) ^ {3{inv}};
        send_frame(1'b1, {1'b0, f, cr});
    endtask

    task automatic do_reset(input bit line);
        sout = line;
        rst  = 1'b1;
        @(posedge clk); #1;
        rst  = 1'b0;
        sout = 1'b1;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        idle(3);

        // model pins: M=1 -> x^3 mod g = x+1; M=x -> x^2+x
        chk("crc_model_pin1", crc_model(32'h0, 4'b0001), 3'b011);
        chk("crc_model_pin2", crc_model(32'h0, 4'b0010), 3'b110);

        // basic result
        send_packet(32'h12345678, 4'b0000);
        idle(2);
        chk("lit_c_12345678", c, 32'h12345678);
        chk("lit_flags_0", flags, 4'b0000);
        chk("lit_crc_ok_1", crc_ok, 1'b1);

        // corrupted crc
        send_packet(32'h0, 4'b0010, 1'b1);
        idle(2);
        chk("lit_crc3_inv", crc3, 3'b001);
`ifdef ALU_SOUT_CRC3_CHECK_EN
        chk("lit_crc_ok_bad", crc_ok, 1'b0);
`else
        chk("lit_crc_ok_bad", crc_ok, 1'b1);
`endif

        // error responses
        send_frame(1'b1, 8'b1_010_010_1);
        idle(1);
        chk("lit_err_flags", err_flags, 3'b010);
        chk("lit_parity_ok", parity_ok, 1'b1);
        send_frame(1'b1, 8'b1_010_010_0);
        idle(1);
        chk("lit_parity_bad", parity_ok, 1'b0);

        // short packet, then a good one
        send_frame(1'b0, 8'hAA);
        send_frame(1'b0, 8'hBB);
        send_frame(1'b1, 8'h00);
        idle(1);
        send_packet(32'hFFFFFFFF, 4'b1010);
        idle(2);
        chk("lit_c_ffffffff", c, 32'hFFFFFFFF);

        // fifth data frame, then a ctl frame with count 0
        for (int i = 0; i < 5; i++) send_frame(1'b0, 8'(i + 1));
        send_frame(1'b1, 8'h05);
        idle(2);

        // error frame mid-packet discards partial data
        send_frame(1'b0, 8'h11);
        send_frame(1'b0, 8'h22);
        send_frame(1'b1, 8'b1_100_100_0);
        send_packet(32'hA5A55A5A, 4'b0101);
        idle(2);

        // bad stop bit on third data frame
        send_frame(1'b0, 8'h01);
        send_frame(1'b0, 8'h02);
        send_frame(1'b0, 8'h03, 1'b0);
        idle(70);

        // reset mid-packet and mid-frame, start bit held low during reset
        send_frame(1'b0, 8'h44);
        send_frame(1'b0, 8'h55);
        sout = 1'b0; @(posedge clk); #1;
        sout = 1'b0; @(posedge clk); #1;
        sout = 1'b1; @(posedge clk); #1;
        sout = 1'b0; @(posedge clk); #1;
        do_reset(1'b0);
        idle(30);
        chk("lit_rst_c", c, 32'h0);
        chk("lit_rst_crc_ok", crc_ok, 1'b0);
        chk("lit_rst_err_flags", err_flags, 3'b000);

        // back-to-back packets, zero gap
        res_cyc.delete();
        send_packet(32'hDEADBEEF, 4'b1000);
        send_packet(32'hCAFEF00D, 4'b0001);
        idle(2);
        chk("b2b_count", res_cyc.size(), 2);
        if (res_cyc.size() == 2) chk("b2b_gap", res_cyc[1] - res_cyc[0], 55);
        chk("lit_c_cafef00d", c, 32'hCAFEF00D);

        // timeout: exactly TO idle cycles is tolerated, TO+1 aborts
        send_frame(1'b0, 8'h10);
        idle(TO);
        send_frame(1'b0, 8'h20);
        send_frame(1'b0, 8'h30);
        send_frame(1'b0, 8'h40);
        send_frame(1'b1, {1'b0, 4'b0011, crc_model(32'h10203040, 4'b0011)});
        idle(2);
        chk("lit_c_timeout_ok", c, 32'h10203040);
        send_frame(1'b0, 8'h77);
        idle(TO + 5);
        send_packet(32'h01020304, 4'b1111);
        idle(3);

        chk("pending_events", exp_kind.num(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_sout_deser.md
Name: alu_sout_deser

Overview:
- Downstream consumer of the serial ALU DUT output line `sout`.
- Deserializes 11-bit frames into either a result (32-bit C, 4 flags, CRC3) or an error response (error flags, parity).
- Feeds the scoreboard/coverage stage with one-cycle strobes.
- Synthesizable; used in the bench and reusable in the FPGA loopback harness.

Parameters:
- DATA_FRAMES, 4, number of data frames preceding a result CTL frame (C is 8*DATA_FRAMES bits; only 4 is supported).
- IDLE_TIMEOUT, 64, max idle cycles allowed between frames of one packet before abort (0 = disabled).

Ports:
- clk  input  1  system clock; `sout` is sampled on every rising edge, one bit per cycle.
- rst  input  1  synchronous, active-high reset.
- sout  input  1  serial line from the DUT; idles high.
- result_valid  output  1  one-cycle strobe: a result packet is complete.
- c  output  32  result data; the first data frame is C[31:24].
- flags  output  4  {carry, overflow, zero, negative}.
- crc3  output  3  CRC field received.
- crc_ok  output  1  received CRC3 matches the computed value.
- err_valid  output  1  one-cycle strobe: an error packet has been received.
- err_flags  output  3  {ERR_DATA, ERR_CRC, ERR_OP}.
- parity_ok  output  1  error CTL byte has even parity.
- proto_err  output  1  one-cycle strobe: malformed frame or packet sequence, or timeout.

Behaviour:
- Frame format, bit order on line: start(0), type(0 = DATA, 1 = CTL), byte MSB first, stop(1). 11 cycles per frame.
- Reset: state IDLE, all strobes 0, c/flags/crc3/err_flags 0, crc_ok 0, parity_ok 0, frame counter 0.
- FSM states:
  - IDLE: start detected on sout = 0 -> TYPE.
  - TYPE: latch the type bit -> DATA.
  - DATA: shift in 8 bits -> STOP.
  - STOP:
    - sout = 0 -> proto_err, counter cleared, -> IDLE.
    - Otherwise decode, then -> IDLE.
  - A new start bit is accepted on the cycle immediately after STOP; back-to-back frames need no gap.
- Decoding in STOP:
  - DATA frame, count < DATA_FRAMES: shift the byte into the C shift register, count++.
  - DATA frame, count = DATA_FRAMES: proto_err, counter cleared.
  - CTL frame, byte[7] = 0 and count = DATA_FRAMES:
    - Load c from the shift register.
    - flags = byte[6:3], crc3 = byte[2:0].
    - Compute crc_ok; pulse result_valid; counter cleared.
  - CTL frame, byte[7] = 0 and count != DATA_FRAMES: proto_err, counter cleared.
  - CTL frame, byte[7] = 1, any count:
    - err_flags = byte[6:4].
    - parity_ok = (^byte == 0).
    - Pulse err_valid; partially collected data is discarded; counter cleared.
    - byte[3:1] duplicates err_flags; a mismatch also sets parity_ok = 0.
- Latency: strobes assert in the cycle after the stop bit is sampled, for exactly 1 cycle. Data outputs hold until the next strobe.
- Strobe exclusivity: result_valid, err_valid and proto_err are mutually exclusive in any cycle.
- Timeout: with count > 0 in IDLE, more than IDLE_TIMEOUT consecutive idle cycles -> proto_err, counter cleared.
- CRC3:
  - Polynomial x^3+x+1, init 000.
  - Computed over the 37 bits {C[31:0], 1'b0, flags[3:0]}, MSB first.
  - The same function is used by the bench model.
- Reset asserted mid-frame or mid-packet:
  - Abort immediately to the reset state.
  - No strobe is issued for the partial packet.
- A start bit arriving during the reset cycle is ignored.

Optional Feature:
- Macro: ALU_SOUT_CRC3_CHECK_EN.
- Defined: crc_ok is computed as above.
- Undefined:
  - The CRC logic is removed and crc_ok = 1 whenever result_valid is high.
  - crc3 is still captured.

Test Plan:
- 4 DATA frames 0x12, 0x34, 0x56, 0x78, then CTL byte {0, 4'b0000, crc3 from model} -> result_valid one cycle after the last stop bit, c = 0x12345678, flags = 0000, crc_ok = 1.
- C = 0x00000000, flags = 4'b0010, CTL crc3 deliberately inverted -> result_valid, crc_ok = 0 (macro on) / 1 (macro off).
- Single CTL byte 8'b1_010_010_1 (ERR_CRC) -> err_valid, err_flags = 010, parity_ok = 1. Same byte with bit 0 flipped -> parity_ok = 0.
- 2 DATA frames followed by a result CTL frame -> proto_err, no result_valid. Next full packet (0xFFFFFFFF) decodes correctly.
- Stop bit forced to 0 on the 3rd data frame -> proto_err on that frame. After a 64+ cycle idle gap, rst pulsed mid-frame -> no strobes; outputs at reset values.
- Two packets back-to-back with zero gap -> two result_valid pulses 55 cycles apart with correct c values.
